// File: rtl/ball_motion_engine.sv
// ball_motion_engine
//   Per-frame ball physics for the Pxs video pipeline. Owns the ball position,
//   direction and speed, advances them once per endframe tick while running,
//   clamps exactly at the walls and reports bounces to the sound block.
//
// Ports
//   px_clk      pixel clock (single clock domain)
//   rst_n       asynchronous active-low reset
//   endframe    1-cycle motion tick at the end of the visible frame
//   start       leave SERVE and begin motion
//   pause       level; ball frozen while high
//   serve       pulse; return ball to serve position and speed
//   inc_vel     pulse; request speed + 1 (sticky until the next RUN tick)
//   dec_vel     pulse; request speed - 1 (sticky until the next RUN tick)
//   x_ball      ball left edge
//   y_ball      ball top edge
//   dx, dy      direction, 0 = right/down, 1 = left/up
//   speed       pixels moved per tick on each axis
//   bounce_x    1-cycle pulse, vertical-wall bounce
//   bounce_y    1-cycle pulse, horizontal-wall bounce
//   bounce_cnt  total bounces, wraps 255 -> 0
//   running     high in RUN
//   state_dbg   current FSM state: 0 = SERVE, 1 = RUN, 2 = PAUSE
//
// Handshake: there is no valid/ready flow here; every control input is
// sampled on each px_clk rising edge, with priority serve > pause > start.
module ball_motion_engine #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int SIZE_BALL  = 16,
  parameter int BORDER     = 0,
  parameter int POS_W      = 10,
  parameter int SPEED_W    = 5,
  parameter int SPEED_INIT = 1,
  parameter int SPEED_MAX  = 20,
  parameter int X_INIT     = (H_ACTIVE - SIZE_BALL) / 4,
  parameter int Y_INIT     = (V_ACTIVE - SIZE_BALL) / 2
) (
  input  logic               px_clk,
  input  logic               rst_n,
  input  logic               endframe,
  input  logic               start,
  input  logic               pause,
  input  logic               serve,
  input  logic               inc_vel,
  input  logic               dec_vel,
  output logic [POS_W-1:0]   x_ball,
  output logic [POS_W-1:0]   y_ball,
  output logic               dx,
  output logic               dy,
  output logic [SPEED_W-1:0] speed,
  output logic               bounce_x,
  output logic               bounce_y,
  output logic [7:0]         bounce_cnt,
  output logic               running,
  output logic [1:0]         state_dbg
);

  localparam int X_MIN = BORDER;
  localparam int Y_MIN = BORDER;
  localparam int X_MAX = H_ACTIVE - SIZE_BALL - BORDER;
  localparam int Y_MAX = V_ACTIVE - SIZE_BALL - BORDER;

  localparam logic [POS_W:0]   X_MIN_W      = (POS_W+1)'(X_MIN);
  localparam logic [POS_W:0]   Y_MIN_W      = (POS_W+1)'(Y_MIN);
  localparam logic [POS_W:0]   X_MAX_W      = (POS_W+1)'(X_MAX);
  localparam logic [POS_W:0]   Y_MAX_W      = (POS_W+1)'(Y_MAX);
  localparam logic [POS_W-1:0] X_INIT_P     = POS_W'(X_INIT);
  localparam logic [POS_W-1:0] Y_INIT_P     = POS_W'(Y_INIT);
  localparam logic [SPEED_W-1:0] SPEED_INIT_P = SPEED_W'(SPEED_INIT);
  localparam logic [SPEED_W-1:0] SPEED_MAX_P  = SPEED_W'(SPEED_MAX);

  // Parameter sanity, caught at elaboration.
  if (X_MAX <= X_MIN || Y_MAX <= Y_MIN) begin : g_bad_field
    $error("ball_motion_engine: playfield has no room for the ball");
  end
  if (SPEED_MAX >= (2 ** SPEED_W) || SPEED_W > POS_W) begin : g_bad_speed
    $error("ball_motion_engine: SPEED_MAX does not fit the speed width");
  end
  if (X_MAX >= (2 ** POS_W) || Y_MAX >= (2 ** POS_W)) begin : g_bad_pos
    $error("ball_motion_engine: POS_W too narrow for the playfield");
  end
  if (X_INIT < X_MIN || X_INIT > X_MAX || Y_INIT < Y_MIN || Y_INIT > Y_MAX) begin : g_bad_init
    $error("ball_motion_engine: serve position outside the playfield");
  end
  if (SPEED_INIT < 0 || SPEED_INIT > SPEED_MAX) begin : g_bad_sinit
    $error("ball_motion_engine: SPEED_INIT outside [0, SPEED_MAX]");
  end

  typedef enum logic [1:0] {
    ST_SERVE = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

  state_t state, state_nx;
  logic   inc_flag, dec_flag;
  logic   req_inc, req_dec;
  logic   tick, reload;
  logic [POS_W:0]   spd_ext;
  logic [POS_W+1:0] x_step, y_step;
  logic [SPEED_W-1:0] speed_nx;

  // One axis step. Returns {bounce, new_dir, new_pos}. Arithmetic is one bit
  // wider than the position so the wall comparisons never wrap.
  function automatic logic [POS_W+1:0] step_axis(
    input logic [POS_W-1:0] pos,
    input logic             dir,
    input logic [POS_W:0]   spd,
    input logic [POS_W:0]   lo,
    input logic [POS_W:0]   hi
  );
    logic [POS_W:0] p;
    logic [POS_W:0] sum;
    logic [POS_W:0] lim;
    p   = {1'b0, pos};
    sum = p + spd;
    lim = lo + spd;
    if (!dir) begin
      if (sum >= hi && spd != '0) step_axis = {1'b1, 1'b1, hi[POS_W-1:0]};
      else                        step_axis = {1'b0, 1'b0, sum[POS_W-1:0]};
    end else begin
      if (p <= lim && spd != '0) begin
        step_axis = {1'b1, 1'b0, lo[POS_W-1:0]};
      end else begin
        sum       = p - spd;
        step_axis = {1'b0, 1'b1, sum[POS_W-1:0]};
      end
    end
  endfunction

  always_comb begin
    state_nx = state;
    case (state)
      ST_SERVE: if (!serve && !pause && start) state_nx = ST_RUN;
      ST_RUN: begin
        if (serve)      state_nx = ST_SERVE;
        else if (pause) state_nx = ST_PAUSE;
      end
      ST_PAUSE: begin
        if (serve)       state_nx = ST_SERVE;
        else if (!pause) state_nx = ST_RUN;
      end
      default: state_nx = ST_SERVE;
    endcase

    // Motion only when RUN holds across the edge that sees endframe.
    tick   = endframe && (state == ST_RUN) && (state_nx == ST_RUN);
    // Sitting in (or entering) SERVE keeps the serve values loaded.
    reload = (state_nx == ST_SERVE);

    spd_ext = {{(POS_W+1-SPEED_W){1'b0}}, speed};
    x_step  = step_axis(x_ball, dx, spd_ext, X_MIN_W, X_MAX_W);
    y_step  = step_axis(y_ball, dy, spd_ext, Y_MIN_W, Y_MAX_W);

    // A pulse arriving on the tick edge itself counts toward that tick.
    req_inc = inc_flag | (inc_vel && (state != ST_SERVE));
    req_dec = dec_flag | (dec_vel && (state != ST_SERVE));

    speed_nx = speed;
    if (req_inc && !req_dec && speed < SPEED_MAX_P)  speed_nx = speed + SPEED_W'(1);
    else if (req_dec && !req_inc && speed != '0)     speed_nx = speed - SPEED_W'(1);
  end

  always_ff @(posedge px_clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_SERVE;
      x_ball     <= X_INIT_P;
      y_ball     <= Y_INIT_P;
      dx         <= 1'b0;
      dy         <= 1'b0;
      speed      <= SPEED_INIT_P;
      bounce_x   <= 1'b0;
      bounce_y   <= 1'b0;
      bounce_cnt <= 8'd0;
      inc_flag   <= 1'b0;
      dec_flag   <= 1'b0;
    end else begin
      state    <= state_nx;
      bounce_x <= 1'b0;
      bounce_y <= 1'b0;
      if (reload) begin
        x_ball   <= X_INIT_P;
        y_ball   <= Y_INIT_P;
        dx       <= 1'b0;
        dy       <= 1'b0;
        speed    <= SPEED_INIT_P;
        inc_flag <= 1'b0;
        dec_flag <= 1'b0;
      end else if (tick) begin
        x_ball     <= x_step[POS_W-1:0];
        dx         <= x_step[POS_W];
        bounce_x   <= x_step[POS_W+1];
        y_ball     <= y_step[POS_W-1:0];
        dy         <= y_step[POS_W];
        bounce_y   <= y_step[POS_W+1];
        bounce_cnt <= bounce_cnt + 8'(x_step[POS_W+1]) + 8'(y_step[POS_W+1]);
        speed      <= speed_nx;
        inc_flag   <= 1'b0;
        dec_flag   <= 1'b0;
      end else begin
        inc_flag <= req_inc;
        dec_flag <= req_dec;
      end
    end
  end

  assign running   = (state == ST_RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_ball_motion_engine.sv
`timescale 1ns/1ps
module tb_ball_motion_engine;

  localparam int X_MIN   = 0;
  localparam int X_MAX   = 624;
  localparam int Y_MIN   = 0;
  localparam int Y_MAX   = 464;
  localparam int SPD_MAX = 20;
  localparam int X_INIT  = 156;
  localparam int Y_INIT  = 232;

  // clock / reset
  logic px_clk = 1'b0;
  logic rst_n  = 1'b1;
  always #5 px_clk = ~px_clk;

  logic endframe = 0, start = 0, pause = 0, serve = 0, inc_vel = 0, dec_vel = 0;

  logic [9:0] x_ball, y_ball;
  logic       dx, dy, bounce_x, bounce_y, running;
  logic [4:0] speed;
  logic [7:0] bounce_cnt;
  logic [1:0] state_dbg;

  logic [9:0] e_x, e_y;
  logic       e_dx, e_dy, e_bx, e_by, e_running;
  logic [4:0] e_speed;
  logic [7:0] e_cnt;
  logic [1:0] e_state;

  ball_motion_engine u_dut (
    .px_clk(px_clk), .rst_n(rst_n), .endframe(endframe), .start(start),
    .pause(pause), .serve(serve), .inc_vel(inc_vel), .dec_vel(dec_vel),
    .x_ball(x_ball), .y_ball(y_ball), .dx(dx), .dy(dy), .speed(speed),
    .bounce_x(bounce_x), .bounce_y(bounce_y), .bounce_cnt(bounce_cnt),
    .running(running), .state_dbg(state_dbg)
  );

  // Serve point close to the right wall with a fast serve speed.
  ball_motion_engine #(.X_INIT(620), .SPEED_INIT(5)) u_edge (
    .px_clk(px_clk), .rst_n(rst_n), .endframe(endframe), .start(start),
    .pause(pause), .serve(serve), .inc_vel(inc_vel), .dec_vel(dec_vel),
    .x_ball(e_x), .y_ball(e_y), .dx(e_dx), .dy(e_dy), .speed(e_speed),
    .bounce_x(e_bx), .bounce_y(e_by), .bounce_cnt(e_cnt),
    .running(e_running), .state_dbg(e_state)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Behavioural reference: ball as integers, mode 0 = serve, 1 = run, 2 = pause.
  int m_x, m_y, m_speed, m_cnt, m_mode;
  bit m_dx, m_dy, m_bx, m_by, m_inc, m_dec;

  logic [37:0] obs_vec;
  assign obs_vec = {x_ball, y_ball, dx, dy, speed, bounce_cnt, running, bounce_x, bounce_y};

  localparam logic [37:0] RESET_VEC = {10'd156, 10'd232, 1'b0, 1'b0, 5'd1, 8'd0, 1'b0, 1'b0, 1'b0};

  function automatic logic [37:0] model_vec();
    logic [9:0] ex, ey;
    logic [4:0] es;
    logic [7:0] ec;
    ex = m_x[9:0];
    ey = m_y[9:0];
    es = m_speed[4:0];
    ec = m_cnt[7:0];
    return {ex, ey, m_dx, m_dy, es, ec, (m_mode == 1), m_bx, m_by};
  endfunction

  function automatic void model_serve();
    m_x = X_INIT; m_y = Y_INIT; m_dx = 0; m_dy = 0; m_speed = 1;
    m_inc = 0; m_dec = 0; m_mode = 0;
  endfunction

  // Move one axis by s pixels, stopping exactly on a wall and reversing there.
  function automatic void model_axis(inout int p, inout bit d, output bit b,
                                     input int lo, input int hi, input int s);
    b = 0;
    if (d == 0) begin
      if (s != 0 && p + s >= hi) begin p = hi; d = 1; b = 1; end
      else p = p + s;
    end else begin
      if (s != 0 && p <= lo + s) begin p = lo; d = 0; b = 1; end
      else p = p - s;
    end
  endfunction

  // driver tasks (each also advances the reference model)
  task automatic hw_reset();
    @(negedge px_clk);
    rst_n = 0; endframe = 0; start = 0; pause = 0; serve = 0; inc_vel = 0; dec_vel = 0;
    repeat (2) @(negedge px_clk);
    rst_n = 1;
    model_serve(); m_cnt = 0; m_bx = 0; m_by = 0;
  endtask

  task automatic op_frame();
    @(negedge px_clk); endframe = 1;
    @(negedge px_clk); endframe = 0;
    m_bx = 0; m_by = 0;
    if (m_mode == 1) begin
      model_axis(m_x, m_dx, m_bx, X_MIN, X_MAX, m_speed);
      model_axis(m_y, m_dy, m_by, Y_MIN, Y_MAX, m_speed);
      m_cnt = (m_cnt + int'(m_bx) + int'(m_by)) % 256;
      if (m_inc && !m_dec)      m_speed = (m_speed + 1 > SPD_MAX) ? SPD_MAX : m_speed + 1;
      else if (m_dec && !m_inc) m_speed = (m_speed - 1 < 0) ? 0 : m_speed - 1;
      m_inc = 0; m_dec = 0;
    end
  endtask

  task automatic op_vel(input bit up, input bit down);
    @(negedge px_clk); inc_vel = up; dec_vel = down;
    @(negedge px_clk); inc_vel = 0; dec_vel = 0;
    m_bx = 0; m_by = 0;
    if (m_mode != 0) begin
      if (up) m_inc = 1;
      if (down) m_dec = 1;
    end
  endtask

  task automatic op_start();
    @(negedge px_clk); start = 1;
    @(negedge px_clk); start = 0;
    m_bx = 0; m_by = 0;
    if (m_mode == 0 && !pause) m_mode = 1;
  endtask

  task automatic op_serve();
    @(negedge px_clk); serve = 1;
    @(negedge px_clk); serve = 0;
    m_bx = 0; m_by = 0;
    model_serve();
  endtask

  task automatic op_pause(input logic v);
    @(negedge px_clk); pause = v;
    @(negedge px_clk);
    m_bx = 0; m_by = 0;
    if (v && m_mode == 1) m_mode = 2;
    else if (!v && m_mode == 2) m_mode = 1;
  endtask

  // tests
  task automatic test_reset();
    @(negedge px_clk); rst_n = 0;
    @(negedge px_clk);
    vectors++;
    if (obs_vec !== RESET_VEC) begin
      miscompares++;
      $display("FAIL reset_values obs=%h exp=%h", obs_vec, RESET_VEC);
    end
    rst_n = 1;
    model_serve(); m_cnt = 0; m_bx = 0; m_by = 0;
    repeat (3) op_frame();
    vectors++;
    if ({x_ball, y_ball, speed, running} !== {10'd156, 10'd232, 5'd1, 1'b0}) begin
      miscompares++;
      $display("FAIL serve_no_start obs x=%0d y=%0d spd=%0d run=%0b exp x=156 y=232 spd=1 run=0",
               x_ball, y_ball, speed, running);
    end
  endtask

  task automatic test_run();
    op_start();
    vectors++;
    if ({running, state_dbg} !== {1'b1, 2'd1}) begin
      miscompares++;
      $display("FAIL start_run obs run=%0b st=%0d exp run=1 st=1", running, state_dbg);
    end
    repeat (4) begin
      op_frame();
      vectors++;
      if ({bounce_x, bounce_y} !== 2'b00) begin
        miscompares++;
        $display("FAIL run_no_bounce obs=%b exp=00", {bounce_x, bounce_y});
      end
    end
    vectors++;
    if ({x_ball, y_ball, dx, dy} !== {10'd160, 10'd236, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL run_4_frames obs x=%0d y=%0d dx=%0b dy=%0b exp x=160 y=236 dx=0 dy=0",
               x_ball, y_ball, dx, dy);
    end
    vectors++;
    if (obs_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL run_model obs=%h exp=%h", obs_vec, model_vec());
    end
  endtask

  task automatic test_wall();
    hw_reset();
    vectors++;
    if ({e_x, e_speed} !== {10'd620, 5'd5}) begin
      miscompares++;
      $display("FAIL edge_reset obs x=%0d spd=%0d exp x=620 spd=5", e_x, e_speed);
    end
    op_start();
    op_frame();
    vectors++;
    if ({e_x, e_y, e_dx, e_bx, e_by, e_cnt} !== {10'd624, 10'd237, 1'b1, 1'b1, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL wall_clamp obs x=%0d y=%0d dx=%0b bx=%0b by=%0b cnt=%0d exp x=624 y=237 dx=1 bx=1 by=0 cnt=1",
               e_x, e_y, e_dx, e_bx, e_by, e_cnt);
    end
    @(negedge px_clk);
    vectors++;
    if (e_bx !== 1'b0) begin
      miscompares++;
      $display("FAIL bounce_pulse_width obs=%0b exp=0", e_bx);
    end
    op_frame();
    vectors++;
    if ({e_x, e_dx, e_cnt} !== {10'd619, 1'b1, 8'd1}) begin
      miscompares++;
      $display("FAIL wall_return obs x=%0d dx=%0b cnt=%0d exp x=619 dx=1 cnt=1", e_x, e_dx, e_cnt);
    end
  endtask

  task automatic test_speed();
    int fx, fy, fc;
    hw_reset();
    op_start();
    repeat (25) begin
      op_vel(1, 0);
      op_frame();
      vectors++;
      if (obs_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL speed_ramp obs=%h exp=%h", obs_vec, model_vec());
      end
    end
    vectors++;
    if (speed !== 5'd20) begin
      miscompares++;
      $display("FAIL speed_saturate obs=%0d exp=20", speed);
    end
    op_vel(1, 1);
    op_frame();
    vectors++;
    if (speed !== 5'd20) begin
      miscompares++;
      $display("FAIL inc_dec_same obs=%0d exp=20", speed);
    end
    repeat (22) begin
      op_vel(0, 1);
      op_frame();
    end
    vectors++;
    if (speed !== 5'd0) begin
      miscompares++;
      $display("FAIL speed_floor obs=%0d exp=0", speed);
    end
    fx = m_x; fy = m_y; fc = m_cnt;
    repeat (3) begin
      op_frame();
      vectors++;
      if ({x_ball, y_ball, bounce_x, bounce_y, bounce_cnt} !==
          {fx[9:0], fy[9:0], 1'b0, 1'b0, fc[7:0]}) begin
        miscompares++;
        $display("FAIL speed0_frozen obs x=%0d y=%0d bx=%0b by=%0b cnt=%0d exp x=%0d y=%0d bx=0 by=0 cnt=%0d",
                 x_ball, y_ball, bounce_x, bounce_y, bounce_cnt, fx, fy, fc);
      end
    end
  endtask

  task automatic test_pause();
    int px, py;
    hw_reset();
    op_start();
    repeat (10) begin op_vel(1, 0); op_frame(); end
    repeat (30) op_frame();
    vectors++;
    if (obs_vec !== model_vec()) begin
      miscompares++;
      $display("FAIL pre_pause obs=%h exp=%h", obs_vec, model_vec());
    end
    if (m_cnt == 0) $display("note: no bounces before pause");
    op_pause(1);
    px = m_x; py = m_y;
    repeat (3) begin
      op_frame();
      vectors++;
      if ({x_ball, y_ball, running} !== {px[9:0], py[9:0], 1'b0}) begin
        miscompares++;
        $display("FAIL pause_frozen obs x=%0d y=%0d run=%0b exp x=%0d y=%0d run=0",
                 x_ball, y_ball, running, px, py);
      end
    end
    op_serve();
    vectors++;
    if ({x_ball, y_ball, speed, state_dbg, running, bounce_cnt} !==
        {10'd156, 10'd232, 5'd1, 2'd0, 1'b0, m_cnt[7:0]}) begin
      miscompares++;
      $display("FAIL serve_from_pause obs x=%0d y=%0d spd=%0d st=%0d run=%0b cnt=%0d exp x=156 y=232 spd=1 st=0 run=0 cnt=%0d",
               x_ball, y_ball, speed, state_dbg, running, bounce_cnt, m_cnt);
    end
    op_pause(0);
  endtask

  task automatic test_async();
    hw_reset();
    op_start();
    repeat (5) begin op_vel(1, 0); op_frame(); end
    @(negedge px_clk);
    #2 rst_n = 0;
    #1;
    vectors++;
    if (obs_vec !== RESET_VEC) begin
      miscompares++;
      $display("FAIL async_reset obs=%h exp=%h", obs_vec, RESET_VEC);
    end
    endframe = 1;
    repeat (3) @(negedge px_clk);
    vectors++;
    if (obs_vec !== RESET_VEC || e_x !== 10'd620) begin
      miscompares++;
      $display("FAIL reset_hold obs=%h ex=%0d exp=%h ex=620", obs_vec, e_x, RESET_VEC);
    end
    endframe = 0;
    rst_n = 1;
    model_serve(); m_cnt = 0; m_bx = 0; m_by = 0;
  endtask

  task automatic test_random();
    int r;
    hw_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      op_frame();
      else if (r < 60) op_vel(1, 0);
      else if (r < 72) op_vel(0, 1);
      else if (r < 76) op_vel(1, 1);
      else if (r < 84) op_pause(!pause);
      else if (r < 94) op_start();
      else             op_serve();
      vectors++;
      if (obs_vec !== model_vec()) begin
        miscompares++;
        $display("FAIL random_step %0d op=%0d obs=%h exp=%h", i, r, obs_vec, model_vec());
      end
    end
    op_pause(0);
  endtask

  task automatic test_wrap();
    int bad;
    bad = 0;
    hw_reset();
    op_start();
    repeat (19) begin op_vel(1, 0); op_frame(); end
    for (int i = 0; i < 4000; i++) begin
      op_frame();
      vectors++;
      if (obs_vec !== model_vec()) begin
        miscompares++;
        bad++;
        if (bad <= 5) $display("FAIL long_run frame %0d obs=%h exp=%h", i, obs_vec, model_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_run();
    test_wall();
    test_speed();
    test_pause();
    test_async();
    test_random();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
